// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port ram8 between a read-only video fetch
// port and a read/write CPU port. At most one access is issued per cycle.
// The acknowledge and read data come back one cycle later. Ties go to the
// port that was not served last, or always to video when VID_PRIORITY is 1.
module ram_arbiter #(
    parameter int unsigned VID_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    // video fetch port (read-only)
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    // cpu port
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    // ram8 side
    output logic        ram_en,
    output logic        ram_wr,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    // One-hot {cpu, vid}: the grant issued last cycle, i.e. this cycle's ack.
    logic [1:0] gnt_q, gnt_d;
    // 1 when the CPU was the most recently granted port.
    logic       last_cpu_q;
    logic       vid_elig, cpu_elig;

    // The ack cycle is masked so a registered requester that is still
    // holding req while it sees its ack is not serviced a second time.
    assign vid_elig = vid_req & ~gnt_q[0];
    assign cpu_elig = cpu_req & ~gnt_q[1];

    // Acks are held off during reset so an access granted just before reset
    // never completes from the requester's point of view.
    assign vid_ack   = gnt_q[0] & ~reset;
    assign cpu_ack   = gnt_q[1] & ~reset;
    assign vid_rdata = vid_ack ? ram_dout : 8'h00;
    assign cpu_rdata = cpu_ack ? ram_dout : 8'h00;

    // Select at most one eligible port for this cycle.
    always_comb begin
        gnt_d = 2'b00;
        if (!reset) begin
            if (vid_elig && cpu_elig) begin
                if ((VID_PRIORITY != 0) || last_cpu_q) begin
                    gnt_d = 2'b01;
                end else begin
                    gnt_d = 2'b10;
                end
            end else begin
                gnt_d = {cpu_elig, vid_elig};
            end
        end
    end

    // Steer the granted port onto the RAM; everything is zero when idle.
    always_comb begin
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = 15'h0000;
        ram_din  = 8'h00;
        unique case (gnt_d)
            2'b01: begin
                ram_en   = 1'b1;
                ram_addr = vid_addr;
            end
            2'b10: begin
                ram_en   = 1'b1;
                ram_wr   = cpu_wr;
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
            end
            default: ;
        endcase
    end

    // Register the grant as next cycle's ack and remember who was served.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q      <= 2'b00;
            last_cpu_q <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            if (gnt_d != 2'b00) begin
                last_cpu_q <= gnt_d[1];
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter in round-robin mode, with a
// second fixed-priority instance driven by the same requests.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic        cpu_req;
    logic        cpu_wr;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;

    logic        vid_ack, cpu_ack, ram_en, ram_wr;
    logic [7:0]  vid_rdata, cpu_rdata, ram_din, ram_dout;
    logic [14:0] ram_addr;

    logic        p_vid_ack, p_cpu_ack, p_ram_en, p_ram_wr;
    logic [7:0]  p_vid_rdata, p_cpu_rdata, p_ram_din, p_ram_dout;
    logic [14:0] p_ram_addr;

    logic [7:0]  mem   [32768];
    logic [7:0]  p_mem [32768];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.VID_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    ram_arbiter #(.VID_PRIORITY(1)) dut_prio (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(p_vid_ack), .vid_rdata(p_vid_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
        .ram_en(p_ram_en), .ram_wr(p_ram_wr), .ram_addr(p_ram_addr), .ram_din(p_ram_din),
        .ram_dout(p_ram_dout)
    );

    // ram8 models: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            if (ram_wr) mem[ram_addr] <= ram_din;
        end
    end

    always @(posedge clk) begin
        if (p_ram_en) begin
            p_ram_dout <= p_mem[p_ram_addr];
            if (p_ram_wr) p_mem[p_ram_addr] <= p_ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single uncontended CPU access: grant this cycle, ack next cycle while
    // the requester still holds req, then req drops.
    task automatic cpu_op(input string tag, input logic wr, input logic [14:0] addr,
                          input logic [7:0] wdata, input logic chk, input logic [7:0] exp);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        check({tag, "_en"}, ram_en, 1);
        check({tag, "_wr"}, ram_wr, wr);
        check({tag, "_addr"}, ram_addr, addr);
        tick();
        #1;
        check({tag, "_ack"}, cpu_ack, 1);
        if (chk) check({tag, "_rdata"}, cpu_rdata, exp);
        check({tag, "_nodup"}, ram_en, 0);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        tick();
    endtask

    int n_en, n_vid, n_cpu, n_alt, p_en, p_cpu;

    initial begin
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        // A request during reset issues nothing.
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 8'hA5;
        #1;
        check("rst_en", ram_en, 0);
        check("rst_wr", ram_wr, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_din", ram_din, 0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_cpu_ack", cpu_ack, 0);
        check("post_rst_vid_ack", vid_ack, 0);
        check("post_rst_rdata", {vid_rdata, cpu_rdata}, 0);
        check("post_rst_en", ram_en, 0);
        tick();

        // CPU write then read back.
        cpu_wdata = 8'hA5;
        #0;
        cpu_op("wr0123", 1'b1, 15'h0123, 8'hA5, 1'b0, 8'h00);
        check("wr0123_din_idle", ram_din, 0);
        cpu_op("rd0123", 1'b0, 15'h0123, 8'h00, 1'b1, 8'hA5);

        // Preload, then simultaneous first requests after reset.
        cpu_op("pre10", 1'b1, 15'h0010, 8'h11, 1'b0, 8'h00);
        cpu_op("pre20", 1'b1, 15'h0020, 8'h22, 1'b0, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vid_req = 1'b1; vid_addr = 15'h0010;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h0020;
        #1;
        check("tie_cpu_first_addr", ram_addr, 15'h0020);
        check("tie_prio_vid_first", p_ram_addr, 15'h0010);
        tick();
        #1;
        check("tie_cpu_ack", cpu_ack, 1);
        check("tie_cpu_rdata", cpu_rdata, 8'h22);
        check("tie_vid_wait", vid_ack, 0);
        check("tie_vid_addr", ram_addr, 15'h0010);
        tick();
        cpu_req = 1'b0;
        #1;
        check("tie_vid_ack", vid_ack, 1);
        check("tie_vid_rdata", vid_rdata, 8'h11);
        check("tie_cpu_noack", cpu_ack, 0);
        check("vid_drop_idle_en", ram_en, 0);
        vid_req = 1'b0;
        tick();

        // Both ports requesting continuously for 20 cycles.
        vid_req = 1'b1; vid_addr = 15'h0100;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h0200;
        n_en = 0; n_vid = 0; n_cpu = 0; n_alt = 0; p_en = 0; p_cpu = 0;
        for (int i = 0; i <= 20; i++) begin
            #1;
            if (i > 0) begin
                n_vid += int'(vid_ack);
                n_cpu += int'(cpu_ack);
                if (vid_ack == cpu_ack) n_alt++;
                p_cpu += int'(p_cpu_ack);
            end
            if (i < 20) begin
                n_en += int'(ram_en);
                p_en += int'(p_ram_en);
            end else begin
                vid_req = 1'b0; cpu_req = 1'b0;
            end
            tick();
        end
        check("rr_en_cycles", n_en, 20);
        check("rr_vid_acks", n_vid, 10);
        check("rr_cpu_acks", n_cpu, 10);
        check("rr_alternate", n_alt, 0);
        check("prio_en_cycles", p_en, 20);
        check("prio_cpu_min9", p_cpu >= 9, 1);

        // Write returns the old byte; a later read sees the new one.
        cpu_op("pre7fff", 1'b1, 15'h7FFF, 8'h3C, 1'b0, 8'h00);
        cpu_op("wr7fff", 1'b1, 15'h7FFF, 8'hC3, 1'b1, 8'h3C);
        cpu_op("rd7fff", 1'b0, 15'h7FFF, 8'h00, 1'b1, 8'hC3);

        // Reset in the cycle after a CPU write grant.
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 8'h5A;
        #1;
        check("mid_grant_en", ram_en, 1);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_cpu_ack", cpu_ack, 0);
        check("mid_rst_vid_ack", vid_ack, 0);
        check("mid_rst_rdata", {vid_rdata, cpu_rdata}, 0);
        check("mid_rst_ram", {ram_en, ram_wr, ram_addr, ram_din}, 0);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_after_cpu_ack", cpu_ack, 0);
        tick();
        cpu_op("mid_rd0123", 1'b0, 15'h0123, 8'h00, 1'b1, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
